ahb_slave_fifo_if: RTL and testbench

- AHB-Lite slave that sits directly downstream of the AHB master and decodes its address/control/data outputs.
- Exposes a memory-mapped TX FIFO, RX FIFO, status and control registers to the SSP/CRC datapath.
- Bus writes to DATA feed the TX FIFO toward the back-end. Back-end results enter the RX FIFO and are read back over AHB.
- Point-to-point: this slave drives the bus HREADY and HRESP seen by the master.

---
 rtl/ahb_slave_fifo_if.sv | 232 +++++++++++++++++++++++
 tb/tb_ahb_slave_fifo_if.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_fifo_if.sv
// ahb_slave_fifo_if: AHB-Lite slave exposing a TX FIFO, an RX FIFO and the
// status/control registers to the SSP/CRC back-end.
//   HCLK, RESET        clock, asynchronous active-low reset
//   HSEL..HMASTLOCK    AHB-Lite address/control/write-data from the master
//   HRDATA/HREADY/HRESP  read data and transfer response to the master
//   tx_data/tx_valid/tx_ready  TX FIFO head toward the back-end
//   rx_data/rx_valid/rx_ready  back-end results into the RX FIFO
//   irq                registered "RX has data" interrupt
// Map (HADDR[3:2]): 0 DATA, 1 STATUS (RO), 2 CTRL, 3 reserved.
module ahb_slave_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  HCLK,
  input  logic                  RESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [2:0]            HBURST,
  input  logic [2:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic                  HMASTLOCK,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  irq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ERR1, ST_ERR2} state_e;

  state_e          state_q, state_d;
  logic [1:0]      addr_q, addr_d;
  logic            write_q, write_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic            tx_en_q, irq_en_q, irq_q;

  logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
  logic [PW-1:0]   tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [CW-1:0]   tx_cnt_q, rx_cnt_q;

  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic            tx_push, tx_pop, rx_push, rx_pop;
  logic            ctrl_wr, tx_flush, rx_flush;
  logic            hready_c, hresp_c;
  logic [DATA_WIDTH-1:0] hrdata_c, status_c, ctrl_rd_c;
  logic            addr_valid, addr_bad;

  // Ignored bus fields kept visible to lint as deliberately unused.
  logic unused_bits;
  assign unused_bits = ^{HBURST, HMASTLOCK, HTRANS[0], HADDR[ADDR_WIDTH-1:4], HADDR[1:0]};

  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  assign status_c  = DATA_WIDTH'({8'(rx_cnt_q), 8'(tx_cnt_q), 4'b0000,
                                  rx_empty, rx_full, tx_empty, tx_full});
  assign ctrl_rd_c = DATA_WIDTH'({irq_en_q, tx_en_q});

  // Data-phase decode: response, read data and FIFO/CTRL side effects.
  // Depends on registered state only, so HREADY never loops back on itself.
  always_comb begin
    hready_c = 1'b1;
    hresp_c  = 1'b0;
    hrdata_c = '0;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    ctrl_wr  = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        case (addr_q)
          A_DATA: begin
            if (write_q) begin
              if (!tx_full) tx_push = 1'b1;
              else          hready_c = 1'b0;
            end else begin
              if (!rx_empty) begin
                hrdata_c = rx_mem_q[rx_rptr_q];
                rx_pop   = 1'b1;
              end else begin
                hready_c = 1'b0;
              end
            end
          end
          A_STATUS: hrdata_c = status_c;
          A_CTRL: begin
            hrdata_c = ctrl_rd_c;
            ctrl_wr  = write_q;
          end
          default: ;
        endcase
      end
      ST_ERR1: begin
        hready_c = 1'b0;
        hresp_c  = 1'b1;
      end
      ST_ERR2: hresp_c = 1'b1;
      default: ;
    endcase
  end

  assign addr_valid = hready_c & HSEL & HTRANS[1];
  assign addr_bad   = (HSIZE != 3'b010) || (HADDR[3:2] == 2'd3) ||
                      ((HADDR[3:2] == A_STATUS) && HWRITE);

  // Next state: sample a new address phase whenever HREADY is high,
  // otherwise step the error response or count a wait cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wait_d  = wait_q;
    if (hready_c) begin
      if (addr_valid) begin
        state_d = addr_bad ? ST_ERR1 : ST_ACCESS;
        addr_d  = HADDR[3:2];
        write_d = HWRITE;
        wait_d  = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (wait_q == TW'(TIMEOUT - 1)) begin
      state_d = ST_ERR1;
    end else begin
      wait_d = wait_q + TW'(1);
    end
  end

  always_ff @(posedge HCLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wait_q  <= wait_d;
    end
  end

  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & rx_ready;
  assign tx_flush = ctrl_wr & HWDATA[2];
  assign rx_flush = ctrl_wr & HWDATA[3];

  // CTRL register and registered interrupt.
  always_ff @(posedge HCLK or negedge RESET) begin
    if (!RESET) begin
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        tx_en_q  <= HWDATA[0];
        irq_en_q <= HWDATA[1];
      end
      irq_q <= irq_en_q & ~rx_empty;
    end
  end

  // TX FIFO pointers/count; a flush overrides any concurrent pop.
  always_ff @(posedge HCLK or negedge RESET) begin
    if (!RESET) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else if (tx_flush) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + PW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PW'(1);
      tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // RX FIFO pointers/count; a flush overrides any concurrent push.
  always_ff @(posedge HCLK or negedge RESET) begin
    if (!RESET) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else if (rx_flush) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + PW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PW'(1);
      rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge HCLK) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= HWDATA;
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
  end

  assign HREADY   = hready_c;
  assign HRESP    = hresp_c;
  assign HRDATA   = hrdata_c;
  assign tx_data  = tx_mem_q[tx_rptr_q];
  assign tx_valid = tx_en_q & ~tx_empty;
  assign rx_ready = ~rx_full;
  assign irq      = irq_q;

endmodule

// File: tb/tb_ahb_slave_fifo_if.sv
// Directed testbench for ahb_slave_fifo_if.
module tb_ahb_slave_fifo_if;

  logic        HCLK;
  logic        RESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HMASTLOCK;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  ahb_slave_fifo_if dut (
    .HCLK(HCLK), .RESET(RESET), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HBURST(HBURST), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HMASTLOCK(HMASTLOCK), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  // Single non-pipelined transfer; counts plain wait and ERR1 cycles.
  task automatic ahb_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic resp, output int waits, output int errs);
    bit done = 0;
    rdata = '0; resp = 1'b0; waits = 0; errs = 0;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge HCLK);
      if (HREADY) begin
        rdata = HRDATA; resp = HRESP; done = 1;
      end else if (HRESP) begin
        errs++;
      end else begin
        waits++;
      end
      @(posedge HCLK); #1;
    end
    if (!done) check("xfer_bound", 32'(done), 32'd1);
  endtask

  // Pipelined INCR write burst to one address; returns total wait cycles.
  task automatic ahb_wr_burst(input logic [31:0] addr, input int n, input logic [31:0] d0,
                              output int waits);
    waits = 0;
    HSEL = 1'b1; HWRITE = 1'b1; HSIZE = 3'b010; HBURST = 3'b001; HADDR = addr; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    for (int i = 0; i < n; i++) begin
      HWDATA = d0 + 32'(i);
      if (i < n - 1) begin HTRANS = 2'b11; HADDR = addr; end
      else begin HSEL = 1'b0; HTRANS = 2'b00; HBURST = 3'b000; end
      for (int c = 0; c < 32; c++) begin
        @(negedge HCLK);
        if (HREADY) break;
        waits++;
      end
      @(posedge HCLK); #1;
    end
  endtask

  logic [31:0] rd;
  logic        rsp;
  int          w, e;

  initial begin
    RESET = 1'b0; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HBURST = '0; HSIZE = 3'b010;
    HTRANS = 2'b00; HWRITE = 1'b0; HMASTLOCK = 1'b0; tx_ready = 1'b0;
    rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_hready", 32'(HREADY), 32'd1);
    check("rst_hresp",  32'(HRESP),  32'd0);
    check("rst_hrdata", HRDATA,      32'd0);
    check("rst_irq",    32'(irq),    32'd0);
    @(negedge HCLK) RESET = 1'b1;
    @(posedge HCLK); #1;

    // Reset asserted in the middle of a write burst's data phase.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0; HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HWDATA = 32'h11; HTRANS = 2'b11;
    #2 RESET = 1'b0;
    #1;
    check("midrst_hready", 32'(HREADY), 32'd1);
    check("midrst_hresp",  32'(HRESP),  32'd0);
    check("midrst_hrdata", HRDATA,      32'd0);
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK) RESET = 1'b1;
    @(posedge HCLK); #1;
    ahb_xfer(32'h4, 1'b0, 3'b010, 32'h0, rd, rsp, w, e);
    check("midrst_status", rd, 32'h0000_000A);

    // TX: fill with a zero-wait burst, then a ninth write stalls until a pop.
    ahb_xfer(32'h8, 1'b1, 3'b010, 32'h1, rd, rsp, w, e);
    check("ctrl1_resp", 32'(rsp), 32'd0);
    ahb_wr_burst(32'h0, 8, 32'hA0, w);
    check("burst_waits", 32'(w), 32'd0);
    ahb_xfer(32'h4, 1'b0, 3'b010, 32'h0, rd, rsp, w, e);
    check("full_status", rd, 32'h0000_0809);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0; HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hA8;
    @(negedge HCLK);
    check("w9_wait", 32'(HREADY), 32'd0);
    @(posedge HCLK); #1;
    tx_ready = 1'b1;
    @(negedge HCLK);
    check("w9_still_wait", 32'(HREADY), 32'd0);
    check("tx_head_a0",    tx_data,     32'hA0);
    check("tx_valid_full", 32'(tx_valid), 32'd1);
    @(posedge HCLK); #1;
    tx_ready = 1'b0;
    @(negedge HCLK);
    check("w9_done",  32'(HREADY), 32'd1);
    check("w9_hresp", 32'(HRESP),  32'd0);
    @(posedge HCLK); #1;
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge HCLK);
      check($sformatf("tx_order_%0d", i), tx_data, 32'hA0 + 32'(i));
      @(posedge HCLK);
    end
    #1 tx_ready = 1'b0;
    @(negedge HCLK);
    check("tx_drained", 32'(tx_valid), 32'd0);
    @(posedge HCLK); #1;

    // Read DATA with RX empty: 16 waits then the two-cycle ERROR.
    ahb_xfer(32'h0, 1'b0, 3'b010, 32'h0, rd, rsp, w, e);
    check("to_waits",  32'(w),   32'd16);
    check("to_err1",   32'(e),   32'd1);
    check("to_err2",   32'(rsp), 32'd1);
    check("to_hrdata", rd,       32'd0);

    // RX path and interrupt.
    rx_valid = 1'b1; rx_data = 32'h55;
    @(negedge HCLK);
    check("rx_ready", 32'(rx_ready), 32'd1);
    @(posedge HCLK); #1;
    rx_data = 32'h66;
    @(posedge HCLK); #1;
    rx_valid = 1'b0;
    ahb_xfer(32'h8, 1'b1, 3'b010, 32'h2, rd, rsp, w, e);
    @(posedge HCLK);
    @(negedge HCLK);
    check("irq_set", 32'(irq), 32'd1);
    @(posedge HCLK); #1;
    ahb_xfer(32'h0, 1'b0, 3'b010, 32'h0, rd, rsp, w, e);
    check("rx_rd0", rd, 32'h55);
    check("rx_rd0_waits", 32'(w), 32'd0);
    ahb_xfer(32'h0, 1'b0, 3'b010, 32'h0, rd, rsp, w, e);
    check("rx_rd1", rd, 32'h66);
    @(posedge HCLK);
    @(negedge HCLK);
    check("irq_clr", 32'(irq), 32'd0);
    @(posedge HCLK); #1;
    ahb_xfer(32'h4, 1'b0, 3'b010, 32'h0, rd, rsp, w, e);
    check("rx_empty_status", rd, 32'h0000_000A);

    // Illegal accesses: bad size, reserved address, STATUS write.
    ahb_xfer(32'h8, 1'b1, 3'b000, 32'hF, rd, rsp, w, e);
    check("bad_size_err", {30'd0, 1'(e == 1), rsp}, 32'd3);
    ahb_xfer(32'hC, 1'b1, 3'b010, 32'hF, rd, rsp, w, e);
    check("rsvd_err", {30'd0, 1'(e == 1), rsp}, 32'd3);
    ahb_xfer(32'h4, 1'b1, 3'b010, 32'hF, rd, rsp, w, e);
    check("status_wr_err", {30'd0, 1'(e == 1), rsp}, 32'd3);
    ahb_xfer(32'h8, 1'b0, 3'b010, 32'h0, rd, rsp, w, e);
    check("err_ctrl_kept", rd, 32'h2);
    check("err_ok_resp", 32'(rsp), 32'd0);
    ahb_xfer(32'h4, 1'b0, 3'b010, 32'h0, rd, rsp, w, e);
    check("err_status_kept", rd, 32'h0000_000A);

    // Flush via CTRL with three TX entries held.
    for (int i = 0; i < 3; i++) ahb_xfer(32'h0, 1'b1, 3'b010, 32'hB0 + 32'(i), rd, rsp, w, e);
    ahb_xfer(32'h4, 1'b0, 3'b010, 32'h0, rd, rsp, w, e);
    check("tx3_status", rd, 32'h0000_0308);
    ahb_xfer(32'h8, 1'b1, 3'b010, 32'h5, rd, rsp, w, e);
    @(negedge HCLK);
    check("flush_tx_valid", 32'(tx_valid), 32'd0);
    @(posedge HCLK); #1;
    ahb_xfer(32'h8, 1'b0, 3'b010, 32'h0, rd, rsp, w, e);
    check("flush_ctrl", rd, 32'h1);
    ahb_xfer(32'h4, 1'b0, 3'b010, 32'h0, rd, rsp, w, e);
    check("flush_status", rd, 32'h0000_000A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
